cypher_entry_controller: RTL and testbench

//  Sequences user code entry into the cypher checker. Accepts one digit per valid/ready handshake from the

---
 rtl/cypher_entry_controller_pkg.sv | 24 ++
 rtl/cypher_entry_controller_timer.sv | 30 +++
 rtl/cypher_entry_controller.sv | 204 ++++++++++++++++++++
 tb/tb_cypher_entry_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cypher_entry_controller_pkg.sv
// Shared state encoding and sizing helpers for the cypher entry controller.
package cypher_entry_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

    localparam int DIGIT_W_DEF = 4;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cypher_entry_controller_timer.sv
// Loadable down-counter with a zero flag; shared by the entry timeout, open and lockout phases.
module cypher_entry_controller_timer #(
    parameter int W = 7
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Counter register: load wins over decrement, decrement saturates at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= W'(0);
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != W'(0))) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == W'(0));

endmodule

// File: rtl/cypher_entry_controller.sv
// Keypad code entry sequencer: collects digits, compares against the stored cypher,
// and drives unlock/fail outcomes with a consecutive-failure lockout.
module cypher_entry_controller
    import cypher_entry_controller_pkg::*;
#(
    parameter int DIGIT_W        = DIGIT_W_DEF,
    parameter int DIGITS         = 4,
    parameter int MAX_FAILS      = 3,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int OPEN_CYCLES    = 16,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cfg_we,
    input  logic [DIGIT_W*DIGITS-1:0]      cfg_cypher,
    input  logic                           digit_valid,
    input  logic [DIGIT_W-1:0]             digit,
    output logic                           digit_ready,
    output logic                           unlock,
    output logic                           unlocked,
    output logic                           fail,
    output logic                           timeout,
    output logic                           locked,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int CW    = DIGIT_W * DIGITS;
    localparam int FC_W  = $clog2(MAX_FAILS + 1);
    localparam int IDX_W = cnt_width(DIGITS);
    localparam int TMR_W = cnt_width(max3(TIMEOUT_CYCLES, OPEN_CYCLES, LOCKOUT_CYCLES));

    state_e            state_r, state_nx_s;
    logic [CW-1:0]     cypher_r, entry_r;
    logic [IDX_W-1:0]  index_r, index_nx_s;
    logic [FC_W-1:0]   fail_count_r, fc_nx_s, fc_inc_s;
    logic              match_r, pend_r, pend_nx_s;
    logic              unlock_r, unlocked_r, fail_r, timeout_r, locked_r;
    logic              unlock_nx_s, unlocked_nx_s, fail_nx_s, timeout_nx_s, locked_nx_s;
    logic              digit_ready_s, accept_s, cypher_we_s, entry_clr_s;
    logic              tmr_load_s, tmr_dec_s, timer_zero_s;
    logic [TMR_W-1:0]  tmr_val_s;

    assign digit_ready_s = ((state_r == ST_IDLE) || (state_r == ST_COLLECT)) && !cfg_we;
    assign accept_s      = digit_valid && digit_ready_s;
    assign fc_inc_s      = fail_count_r + FC_W'(1);

    cypher_entry_controller_timer #(.W(TMR_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load_s),
        .load_value (tmr_val_s),
        .dec        (tmr_dec_s),
        .zero       (timer_zero_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nx_s    = state_r;
        index_nx_s    = index_r;
        pend_nx_s     = 1'b0;
        fc_nx_s       = fail_count_r;
        unlock_nx_s   = 1'b0;
        unlocked_nx_s = unlocked_r;
        fail_nx_s     = 1'b0;
        timeout_nx_s  = 1'b0;
        locked_nx_s   = locked_r;
        cypher_we_s   = 1'b0;
        entry_clr_s   = 1'b0;
        tmr_load_s    = 1'b0;
        tmr_dec_s     = 1'b0;
        tmr_val_s     = TMR_W'(0);
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if ((state_r == ST_IDLE) && cfg_we) begin
                    cypher_we_s = 1'b1;
                    fc_nx_s     = FC_W'(0);
                end else if (accept_s) begin
                    if (index_r == IDX_W'(DIGITS - 1)) begin
                        index_nx_s = IDX_W'(0);
                        state_nx_s = ST_CHECK;
                    end else begin
                        index_nx_s = index_r + IDX_W'(1);
                        tmr_load_s = 1'b1;
                        tmr_val_s  = TMR_W'(TIMEOUT_CYCLES - 1);
                        state_nx_s = ST_COLLECT;
                    end
                end else if (state_r == ST_COLLECT) begin
                    if (timer_zero_s) begin
                        timeout_nx_s = 1'b1;
                        entry_clr_s  = 1'b1;
                        index_nx_s   = IDX_W'(0);
                        state_nx_s   = ST_IDLE;
                    end else begin
                        tmr_dec_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            // First cycle registers the compare; the outcome is applied in the second.
            ST_CHECK: begin
                if (!pend_r) begin
                    pend_nx_s = 1'b1;
                end else begin
                    entry_clr_s = 1'b1;
                    if (match_r) begin
                        unlock_nx_s   = 1'b1;
                        unlocked_nx_s = 1'b1;
                        fc_nx_s       = FC_W'(0);
                        tmr_load_s    = 1'b1;
                        tmr_val_s     = TMR_W'(OPEN_CYCLES - 1);
                        state_nx_s    = ST_OPEN;
                    end else begin
                        fail_nx_s = 1'b1;
                        fc_nx_s   = fc_inc_s;
                        if (fc_inc_s == FC_W'(MAX_FAILS)) begin
                            locked_nx_s = 1'b1;
                            tmr_load_s  = 1'b1;
                            tmr_val_s   = TMR_W'(LOCKOUT_CYCLES - 1);
                            state_nx_s  = ST_LOCKOUT;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (timer_zero_s) begin
                    unlocked_nx_s = 1'b0;
                    state_nx_s    = ST_IDLE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (timer_zero_s) begin
                    locked_nx_s = 1'b0;
                    fc_nx_s     = FC_W'(0);
                    state_nx_s  = ST_IDLE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            default: begin
                unlocked_nx_s = 1'b0;
                locked_nx_s   = 1'b0;
                entry_clr_s   = 1'b1;
                index_nx_s    = IDX_W'(0);
                state_nx_s    = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cypher_r     <= CW'(0);
            entry_r      <= CW'(0);
            index_r      <= IDX_W'(0);
            fail_count_r <= FC_W'(0);
            match_r      <= 1'b0;
            pend_r       <= 1'b0;
            unlock_r     <= 1'b0;
            unlocked_r   <= 1'b0;
            fail_r       <= 1'b0;
            timeout_r    <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            index_r      <= index_nx_s;
            fail_count_r <= fc_nx_s;
            match_r      <= (entry_r == cypher_r);
            pend_r       <= pend_nx_s;
            unlock_r     <= unlock_nx_s;
            unlocked_r   <= unlocked_nx_s;
            fail_r       <= fail_nx_s;
            timeout_r    <= timeout_nx_s;
            locked_r     <= locked_nx_s;
            if (cypher_we_s) begin
                cypher_r <= cfg_cypher;
            end else begin
                cypher_r <= cypher_r;
            end
            if (entry_clr_s) begin
                entry_r <= CW'(0);
            end else if (accept_s) begin
                entry_r <= (entry_r << DIGIT_W) | CW'(digit);
            end else begin
                entry_r <= entry_r;
            end
        end
    end

    assign digit_ready = digit_ready_s;
    assign unlock      = unlock_r;
    assign unlocked    = unlocked_r;
    assign fail        = fail_r;
    assign timeout     = timeout_r;
    assign locked      = locked_r;
    assign fail_count  = fail_count_r;

endmodule

// File: tb/tb_cypher_entry_controller.sv
// Self-checking bench: directed table, corner-case sequences and random traffic against a queue-based model.
module tb_cypher_entry_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_cypher = 16'h0000;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'h0;
    logic        digit_ready, unlock, unlocked, fail, timeout, locked;
    logic [1:0]  fail_count;

    always #5 clock = ~clock;

    cypher_entry_controller dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_cypher  (cfg_cypher),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_ready (digit_ready),
        .unlock      (unlock),
        .unlocked    (unlocked),
        .fail        (fail),
        .timeout     (timeout),
        .locked      (locked),
        .fail_count  (fail_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: digits held in a queue, phase ages counted upward in plain cycles.
    localparam int M_IDLE = 0, M_COLLECT = 1, M_CHECK = 2, M_OPEN = 3, M_LOCK = 4;
    int          m_mode, m_fails, m_age;
    int          m_q[$];
    logic [15:0] m_cy;
    logic        m_unlock, m_unlocked, m_fail, m_timeout, m_locked;

    function automatic void m_reset();
        m_mode = M_IDLE; m_fails = 0; m_age = 0; m_q.delete(); m_cy = 16'h0000;
        m_unlock = 1'b0; m_unlocked = 1'b0; m_fail = 1'b0; m_timeout = 1'b0; m_locked = 1'b0;
    endfunction

    function automatic logic m_ready(input logic we);
        return ((m_mode == M_IDLE) || (m_mode == M_COLLECT)) && !we;
    endfunction

    function automatic void m_step(input logic we, input logic [15:0] cy, input logic dv, input logic [3:0] d);
        logic acc;
        int   val;
        acc = dv && m_ready(we);
        m_unlock = 1'b0; m_fail = 1'b0; m_timeout = 1'b0;
        case (m_mode)
            M_IDLE, M_COLLECT: begin
                if (m_mode == M_IDLE && we) begin
                    m_cy = cy;
                    m_fails = 0;
                end
                if (acc) begin
                    m_q.push_back(int'(d));
                    m_age = 0;
                    m_mode = (m_q.size() == 4) ? M_CHECK : M_COLLECT;
                end else if (m_mode == M_COLLECT) begin
                    m_age++;
                    if (m_age == 32) begin
                        m_timeout = 1'b1;
                        m_q.delete();
                        m_mode = M_IDLE;
                    end
                end
            end
            M_CHECK: begin
                m_age++;
                if (m_age == 2) begin
                    val = 0;
                    foreach (m_q[i]) val = val * 16 + m_q[i];
                    m_q.delete();
                    if (val == int'(m_cy)) begin
                        m_unlock = 1'b1; m_unlocked = 1'b1; m_fails = 0; m_age = 0; m_mode = M_OPEN;
                    end else begin
                        m_fail = 1'b1;
                        m_fails++;
                        if (m_fails == 3) begin
                            m_locked = 1'b1; m_age = 0; m_mode = M_LOCK;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
            M_OPEN: begin
                m_age++;
                if (m_age == 16) begin
                    m_unlocked = 1'b0; m_mode = M_IDLE;
                end
            end
            M_LOCK: begin
                m_age++;
                if (m_age == 64) begin
                    m_locked = 1'b0; m_fails = 0; m_mode = M_IDLE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic we, input logic [15:0] cy, input logic dv, input logic [3:0] d);
        cfg_we = we; cfg_cypher = cy; digit_valid = dv; digit = d;
        #1;
        chk("digit_ready", 32'(digit_ready), 32'(m_ready(we)));
        @(posedge clock);
        m_step(we, cy, dv, d);
        #1;
        chk("outputs", 32'({unlock, unlocked, fail, timeout, locked, fail_count}),
            32'({m_unlock, m_unlocked, m_fail, m_timeout, m_locked, 2'(m_fails)}));
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 16'h0000, 1'b0, 4'h0);
    endtask

    task automatic enter(input logic [15:0] code);
        for (int k = 3; k >= 0; k--) tick(1'b0, 16'h0000, 1'b1, code[4*k +: 4]);
    endtask

    function automatic logic [15:0] rand_code();
        logic [15:0] c;
        for (int k = 0; k < 4; k++) c[4*k +: 4] = 4'($urandom_range(0, 1));
        return c;
    endfunction

    typedef struct {
        logic        we;
        logic [15:0] cy;
        logic        dv;
        logic [3:0]  d;
        logic        e_unlock;
        logic        e_unlocked;
        logic        e_fail;
        logic [1:0]  e_fc;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = '{1'b1, 16'h2601, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0};

        m_reset();
        #3;
        chk("reset_state", 32'({digit_ready, unlock, unlocked, fail, timeout, locked, fail_count}), 32'(8'b1000_0000));
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        m_step(1'b0, 16'h0000, 1'b0, 4'h0);
        #1;

        // Directed table: a wrong code, then the right one.
        for (int i = 0; i < 15; i++) begin
            tick(tbl[i].we, tbl[i].cy, tbl[i].dv, tbl[i].d);
            chk("table", 32'({unlock, unlocked, fail, fail_count}),
                32'({tbl[i].e_unlock, tbl[i].e_unlocked, tbl[i].e_fail, tbl[i].e_fc}));
        end
        n = 2;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            if (unlocked) n++;
            else break;
        end
        chk("open_length", 32'(n), 32'd16);

        // Three wrong codes lead to a 64-cycle lockout that ignores digits.
        for (int k = 0; k < 3; k++) begin
            enter(16'h1234);
            idle(2);
        end
        chk("lock_set", 32'({locked, fail_count}), 32'({1'b1, 2'd3}));
        n = 1;
        for (int k = 0; k < 100; k++) begin
            tick(1'b0, 16'h0000, 1'b1, 4'($urandom_range(0, 15)));
            if (locked) n++;
            else break;
        end
        chk("lock_length", 32'(n), 32'd64);
        chk("lock_exit_fc", 32'(fail_count), 32'd0);

        // Partial entry timeout leaves the failure count alone.
        enter(16'h9999);
        idle(2);
        tick(1'b0, 16'h0000, 1'b1, 4'h2);
        tick(1'b0, 16'h0000, 1'b1, 4'h6);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            idle(1);
            n++;
            if (timeout) break;
        end
        chk("timeout_gap", 32'(n), 32'd32);
        chk("timeout_fc", 32'(fail_count), 32'd1);
        enter(16'h2601);
        idle(2);
        chk("after_timeout_unlock", 32'({unlock, fail_count}), 32'({1'b1, 2'd0}));
        idle(16);

        // cfg_we is ignored mid-entry, and wins over a digit in IDLE.
        tick(1'b0, 16'h0000, 1'b1, 4'h2);
        tick(1'b0, 16'h0000, 1'b1, 4'h6);
        tick(1'b1, 16'h1111, 1'b0, 4'h0);
        tick(1'b0, 16'h0000, 1'b1, 4'h0);
        tick(1'b0, 16'h0000, 1'b1, 4'h1);
        idle(2);
        chk("cfg_ignored_unlock", 32'(unlock), 32'd1);
        idle(16);
        tick(1'b1, 16'h1111, 1'b1, 4'h5);
        enter(16'h1111);
        idle(2);
        chk("cfg_loaded_unlock", 32'(unlock), 32'd1);
        idle(16);

        // Reset in the middle of a lockout.
        for (int k = 0; k < 3; k++) begin
            enter(16'h1234);
            idle(2);
        end
        idle(10);
        chk("pre_reset_locked", 32'(locked), 32'd1);
        reset = 1'b0;
        #2;
        chk("reset_abort", 32'({locked, digit_ready, fail_count}), 32'({1'b0, 1'b1, 2'd0}));
        @(negedge clock);
        reset = 1'b1;
        m_reset();
        @(posedge clock);
        m_step(1'b0, 16'h0000, 1'b0, 4'h0);
        #1;
        enter(16'h0000);
        idle(2);
        chk("post_reset_unlock", 32'(unlock), 32'd1);
        idle(16);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                idle(35);
            end else begin
                tick(($urandom_range(0, 39) == 0), rand_code(), ($urandom_range(0, 9) < 6),
                     4'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
